// File: rtl/shift_sequencer_if.sv
// Request, shifter-drive and result bus of shift_sequencer.
// slave = sequencer side, master = surrounding environment side.
interface shift_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic        in_dir;
  logic [1:0]  in_op;
  logic [31:0] sh_A;
  logic        sh_d;
  logic [4:0]  sh_amt;
  logic [31:0] sh_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport slave (
    input  in_valid, in_data, in_amt, in_dir, in_op, sh_result, out_ready,
    output in_ready, sh_A, sh_d, sh_amt, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_amt, in_dir, in_op, sh_result, out_ready,
    input  in_ready, sh_A, sh_d, sh_amt, out_valid, out_data
  );
endinterface

// File: rtl/shift_sequencer.sv
// Sequential front-end for the 32-bit combinational barrel shifter.
// SHIFT takes one pass; ROTATE takes two passes whose results are OR-ed.
module shift_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  shift_sequencer_if.slave  bus,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS1 = 2'd1,
    S_PASS2 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_data;
  logic [4:0]       r_amt;
  logic             r_dir;
  logic [1:0]       r_op;
  logic [31:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_ready;
  logic             w_is_rot;
  logic [4:0]       w_amt_comp;
  logic [31:0]      w_sh_A;
  logic             w_sh_d;
  logic [4:0]       w_sh_amt;

  assign w_in_ready = (r_state == S_IDLE) && reset_n;
  assign w_is_rot   = (r_op == 2'b01);
  // 32 - amt modulo 32; amt is nonzero whenever this is used
  assign w_amt_comp = 5'd0 - r_amt;

  // State, operand latch, accumulator and completion counter
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_amt   <= '0;
      r_dir   <= 1'b0;
      r_op    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && w_in_ready) begin
            r_data <= bus.in_data;
            r_amt  <= bus.in_amt;
            r_dir  <= bus.in_dir;
            r_op   <= bus.in_op;
          end
        end
        S_PASS1: r_acc <= bus.sh_result;
        S_PASS2: r_acc <= r_acc | bus.sh_result;
        S_DONE: begin
          if (bus.out_ready) r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and shifter drive
  always_comb begin
    w_next   = r_state;
    w_sh_A   = '0;
    w_sh_d   = 1'b0;
    w_sh_amt = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid && w_in_ready) w_next = S_PASS1;
      end
      S_PASS1: begin
        w_sh_A   = r_data;
        w_sh_d   = r_dir;
        w_sh_amt = r_amt;
        w_next   = (w_is_rot && (r_amt != 5'd0)) ? S_PASS2 : S_DONE;
      end
      S_PASS2: begin
        w_sh_A   = r_data;
        w_sh_d   = ~r_dir;
        w_sh_amt = w_amt_comp;
        w_next   = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.sh_A      = w_sh_A;
  assign bus.sh_d      = w_sh_d;
  assign bus.sh_amt    = w_sh_amt;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_data  = r_acc;
  assign busy          = (r_state != S_IDLE);
  assign op_count      = r_cnt;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed testbench for shift_sequencer with a behavioural barrel shifter.
module tb_shift_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       busy;
  logic [3:0] op_count;
  int         errors = 0;
  int         checks = 0;
  int         exp_cnt = 0;

  always #5 clock = ~clock;

  shift_sequencer_if bus ();

  // Combinational barrel shifter the sequencer drives
  assign bus.sh_result = bus.sh_d ? (bus.sh_A >> bus.sh_amt) : (bus.sh_A << bus.sh_amt);

  shift_sequencer #(.CNT_W(4)) u_dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a request and return just after the accept edge (state PASS1)
  task automatic send(input logic [31:0] d, input logic [4:0] a, input logic dir,
                      input logic [1:0] op);
    int k;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_dir   = dir;
    bus.in_op    = op;
    #1;
    k = 0;
    while (!bus.in_ready && k < 20) begin
      step();
      k++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  // Consume the result currently held in DONE
  task automatic drain();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 16;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
    checks++;
    if (op_count !== 4'd0) begin errors++; $display("FAIL rst_op_count: got %0d want 0", op_count); end
    checks++;
    if (busy !== 1'b0 || bus.sh_A !== 32'h0 || bus.sh_amt !== 5'd0 || bus.sh_d !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle_drive: busy=%b sh_A=%h sh_d=%b sh_amt=%0d want 0", busy, bus.sh_A, bus.sh_d, bus.sh_amt);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", bus.in_ready); end
    exp_cnt = 0;
  endtask

  task automatic test_shift_left();
    send(32'h0000_0001, 5'd4, 1'b0, 2'b00);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sh_A !== 32'h1 || bus.sh_amt !== 5'd4 || bus.sh_d !== 1'b0) begin
      errors++;
      $display("FAIL shl_pass1: ov=%b sh_A=%h sh_d=%b sh_amt=%0d want 0/00000001/0/4", bus.out_valid, bus.sh_A, bus.sh_d, bus.sh_amt);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_0010) begin
      errors++;
      $display("FAIL shl_result: ov=%b data=%h want 1/00000010", bus.out_valid, bus.out_data);
    end
    drain();
    checks++;
    if (op_count !== 4'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL shl_count: op_count=%0d busy=%b want 1/0", op_count, busy);
    end
  endtask

  task automatic test_rotate_right();
    send(32'h0000_00F1, 5'd4, 1'b1, 2'b01);
    checks++;
    if (bus.sh_d !== 1'b1 || bus.sh_amt !== 5'd4) begin
      errors++;
      $display("FAIL rotr_pass1: sh_d=%b sh_amt=%0d want 1/4", bus.sh_d, bus.sh_amt);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sh_d !== 1'b0 || bus.sh_amt !== 5'd28 || bus.sh_A !== 32'hF1) begin
      errors++;
      $display("FAIL rotr_pass2: ov=%b sh_A=%h sh_d=%b sh_amt=%0d want 0/000000f1/0/28", bus.out_valid, bus.sh_A, bus.sh_d, bus.sh_amt);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1000_000F) begin
      errors++;
      $display("FAIL rotr_result: ov=%b data=%h want 1/1000000f", bus.out_valid, bus.out_data);
    end
    drain();
  endtask

  task automatic test_rotate_left();
    send(32'h8000_0001, 5'd1, 1'b0, 2'b01);
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_0003) begin
      errors++;
      $display("FAIL rotl_result: ov=%b data=%h want 1/00000003", bus.out_valid, bus.out_data);
    end
    drain();
    // Rotate by zero skips the second pass
    send(32'hDEAD_BEEF, 5'd0, 1'b0, 2'b01);
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rot0_result: ov=%b data=%h want 1/deadbeef", bus.out_valid, bus.out_data);
    end
    drain();
    // Opcode 10 behaves as a one-pass SHIFT
    send(32'h8000_0001, 5'd1, 1'b1, 2'b10);
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h4000_0000) begin
      errors++;
      $display("FAIL op10_result: ov=%b data=%h want 1/40000000", bus.out_valid, bus.out_data);
    end
    drain();
    checks++;
    if (op_count !== 4'(exp_cnt)) begin
      errors++;
      $display("FAIL rot_count: op_count=%0d want %0d", op_count, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    send(32'h0000_000F, 5'd8, 1'b0, 2'b00);
    step();
    // Second request presented while the first result is stalled
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h1234_5678;
    bus.in_amt   = 5'd4;
    bus.in_dir   = 1'b1;
    bus.in_op    = 2'b00;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_0F00 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: ov=%b data=%h in_ready=%b want 1/00000f00/0", i, bus.out_valid, bus.out_data, bus.in_ready);
      end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 16;
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: busy=%b in_ready=%b want 0/1", busy, bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || bus.sh_A !== 32'h1234_5678) begin
      errors++;
      $display("FAIL bp_second_accept: busy=%b sh_A=%h want 1/12345678", busy, bus.sh_A);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0123_4567) begin
      errors++;
      $display("FAIL bp_second_result: ov=%b data=%h want 1/01234567", bus.out_valid, bus.out_data);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    send(32'h0000_00F1, 5'd4, 1'b1, 2'b01);
    step();
    checks++;
    if (bus.sh_amt !== 5'd28 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_pass2: sh_amt=%0d busy=%b want 28/1", bus.sh_amt, busy);
    end
    reset_n = 1'b0;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || op_count !== 4'd0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: ov=%b data=%h cnt=%0d busy=%b in_ready=%b want 0/0/0/0/0",
               bus.out_valid, bus.out_data, op_count, busy, bus.in_ready);
    end
    reset_n = 1'b1;
    #1;
    exp_cnt = 0;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++) begin
      send(32'(i + 1), 5'd1, 1'b0, 2'b00);
      step();
      checks++;
      if (bus.out_data !== 32'((i + 1) * 2)) begin
        errors++;
        $display("FAIL wrap_data[%0d]: got %h want %h", i, bus.out_data, 32'((i + 1) * 2));
      end
      drain();
    end
    checks++;
    if (op_count !== 4'd1 || op_count !== 4'(exp_cnt)) begin
      errors++;
      $display("FAIL wrap_count: op_count=%0d want 1", op_count);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_dir    = 1'b0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_shift_left();
    test_rotate_right();
    test_rotate_left();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
